// File: rtl/pid_math_seq_pkg.sv
// Shared types and ALU select encodings for the PID math sequencer.
// The control decode lives here so the state table is defined in one place.
package pid_math_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StErr,
    StIntg,
    StIcomp,
    StPcomp,
    StAcc1,
    StAcc2,
    StDone
  } state_e;

  localparam logic [2:0] Src0A2d    = 3'd0;
  localparam logic [2:0] Src0Intgrl = 3'd1;
  localparam logic [2:0] Src0Icomp  = 3'd2;
  localparam logic [2:0] Src0Pcomp  = 3'd3;
  localparam logic [2:0] Src0Pterm  = 3'd4;

  localparam logic [2:0] Src1Accum   = 3'd0;
  localparam logic [2:0] Src1Iterm   = 3'd1;
  localparam logic [2:0] Src1Err     = 3'd2;
  localparam logic [2:0] Src1ErrDiv2 = 3'd3;
  localparam logic [2:0] Src1Fwd     = 3'd4;

  typedef struct packed {
    logic [2:0] src0sel;
    logic [2:0] src1sel;
    logic       multiply;
    logic       sub;
    logic       mult2;
    logic       mult4;
    logic       saturate;
  } alu_ctrl_t;

  // Moore decode of the ALU controls; mult2/mult4 are never asserted.
  function automatic alu_ctrl_t alu_ctrl(state_e st);
    alu_ctrl_t c;
    c = '0;
    unique case (st)
      StErr: begin
        c.src0sel  = Src0A2d;
        c.src1sel  = Src1Fwd;
        c.sub      = 1'b1;
        c.saturate = 1'b1;
      end
      StIntg: begin
        c.src0sel  = Src0Intgrl;
        c.src1sel  = Src1ErrDiv2;
        c.saturate = 1'b1;
      end
      StIcomp: begin
        c.src0sel  = Src0Intgrl;
        c.src1sel  = Src1Iterm;
        c.multiply = 1'b1;
      end
      StPcomp: begin
        c.src0sel  = Src0Pterm;
        c.src1sel  = Src1Err;
        c.multiply = 1'b1;
      end
      StAcc1: begin
        c.src0sel = Src0Pcomp;
        c.src1sel = Src1Fwd;
      end
      StAcc2: begin
        c.src0sel  = Src0Icomp;
        c.src1sel  = Src1Accum;
        c.saturate = 1'b1;
      end
      StIdle, StDone: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pid_math_seq_if.sv
// ALU control/result bus between the sequencer (master) and the PID ALU (slave).
interface pid_math_seq_if;
  logic [2:0]  src0sel;
  logic [2:0]  src1sel;
  logic        multiply;
  logic        sub;
  logic        mult2;
  logic        mult4;
  logic        saturate;
  logic [15:0] dst;

  modport master (
    output src0sel, src1sel, multiply, sub, mult2, mult4, saturate,
    input  dst
  );

  modport slave (
    input  src0sel, src1sel, multiply, sub, mult2, mult4, saturate,
    output dst
  );
endinterface

// File: rtl/intg_prescaler.sv
// Modulo-INTG_DIV counter; tick is high while the count is zero.
module intg_prescaler #(
  parameter int unsigned INTG_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic tick
);

  localparam int unsigned CntW = (INTG_DIV > 1) ? $clog2(INTG_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = (cnt_q == CntW'(INTG_DIV - 1)) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/pid_math_seq.sv
// PID math sequencer: walks the ALU through one fixed 7-cycle computation per start
// strobe and captures each ALU result into the working register it feeds.
module pid_math_seq
  import pid_math_seq_pkg::*;
#(
  parameter int unsigned INTG_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  pid_math_seq_if.master       alu,
  output logic [11:0]          Error,
  output logic [11:0]          Intgrl,
  output logic [11:0]          Icomp,
  output logic [15:0]          Pcomp,
  output logic [15:0]          Accum,
  output logic                 busy,
  output logic                 done
);

  state_e      state_q, state_d;
  alu_ctrl_t   ctrl;
  logic        intg_tick;
  logic [11:0] error_q, error_d;
  logic [11:0] intgrl_q, intgrl_d;
  logic [11:0] icomp_q, icomp_d;
  logic [15:0] pcomp_q, pcomp_d;
  logic [15:0] accum_q, accum_d;

  intg_prescaler #(
    .INTG_DIV (INTG_DIV)
  ) u_intg_prescaler (
    .clk  (clk),
    .rst  (rst),
    .inc  (state_q == StDone),
    .tick (intg_tick)
  );

  always_comb begin
    state_d  = state_q;
    error_d  = error_q;
    intgrl_d = intgrl_q;
    icomp_d  = icomp_q;
    pcomp_d  = pcomp_q;
    accum_d  = accum_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StErr;
      end
      StErr: begin
        error_d = alu.dst[11:0];
        state_d = StIntg;
      end
      StIntg: begin
        // The integrator is only advanced on prescaler ticks; the state is still visited.
        if (intg_tick) intgrl_d = alu.dst[11:0];
        state_d = StIcomp;
      end
      StIcomp: begin
        icomp_d = alu.dst[11:0];
        state_d = StPcomp;
      end
      StPcomp: begin
        pcomp_d = alu.dst;
        state_d = StAcc1;
      end
      StAcc1: begin
        accum_d = alu.dst;
        state_d = StAcc2;
      end
      StAcc2: begin
        accum_d = alu.dst;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      error_q  <= '0;
      intgrl_q <= '0;
      icomp_q  <= '0;
      pcomp_q  <= '0;
      accum_q  <= '0;
    end else begin
      state_q  <= state_d;
      error_q  <= error_d;
      intgrl_q <= intgrl_d;
      icomp_q  <= icomp_d;
      pcomp_q  <= pcomp_d;
      accum_q  <= accum_d;
    end
  end

  always_comb begin
    ctrl         = alu_ctrl(state_q);
    alu.src0sel  = ctrl.src0sel;
    alu.src1sel  = ctrl.src1sel;
    alu.multiply = ctrl.multiply;
    alu.sub      = ctrl.sub;
    alu.mult2    = ctrl.mult2;
    alu.mult4    = ctrl.mult4;
    alu.saturate = ctrl.saturate;
  end

  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign done   = (state_q == StDone);
  assign Error  = error_q;
  assign Intgrl = intgrl_q;
  assign Icomp  = icomp_q;
  assign Pcomp  = pcomp_q;
  assign Accum  = accum_q;

endmodule
